// File: rtl/dma_controller.sv
// Bus-master DMA engine: on a cmd pulse it requests the shared data-memory bus,
// writes a fixed block of device words in 64-bit bursts, then releases the bus.
module dma_controller #(
    parameter logic [15:0] BASE_ADDR       = 16'h01f4,
    parameter int          LENGTH          = 12,
    parameter int          WORDS_PER_BURST = 4,
    parameter int          MEM_LATENCY     = 4,
    localparam int         NUM_BURSTS      = LENGTH / WORDS_PER_BURST,
    localparam int         IDX_W           = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             cmd,
    input  logic             BG,
    output logic             BR,
    output logic             dma_end,
    output logic             busy,
    output logic [IDX_W-1:0] dev_index,
    input  logic [63:0]      dev_data,
    output logic             d_readM,
    output logic             d_writeM,
    output logic [15:0]      d_address,
    inout  wire  [63:0]      d_data
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WRITE   = 3'd2,
        GAP     = 3'd3,
        DONE    = 3'd4,
        RELEASE = 3'd5
    } dmaState_t;

    dmaState_t        state_r;
    dmaState_t        nextState_s;
    logic [IDX_W-1:0] burstCnt_r;
    logic [IDX_W-1:0] nextBurstCnt_s;
    logic [CNT_W-1:0] cycleCnt_r;
    logic [CNT_W-1:0] nextCycleCnt_s;
    logic [63:0]      dataReg_r;
    logic [63:0]      nextData_s;
    logic             busReq_r;
    logic             dmaEnd_r;
    logic             busy_r;
    logic             writeStrobe_s;
    logic [15:0]      burstAddr_s;

    // Next-state, counter and burst-data logic
    always_comb begin
        nextState_s    = state_r;
        nextBurstCnt_s = burstCnt_r;
        nextCycleCnt_s = cycleCnt_r;
        nextData_s     = dataReg_r;
        case (state_r)
            IDLE: begin
                if (cmd) begin
                    nextState_s    = REQ;
                    nextBurstCnt_s = {IDX_W{1'b0}};
                    nextCycleCnt_s = {CNT_W{1'b0}};
                end else begin
                    nextState_s = IDLE;
                end
            end
            REQ: begin
                if (BG) begin
                    nextData_s  = dev_data;
                    nextState_s = WRITE;
                end else begin
                    nextState_s = REQ;
                end
            end
            WRITE: begin
                // A dropped grant freezes the burst in place until BG returns
                if (BG) begin
                    nextCycleCnt_s = cycleCnt_r + CNT_W'(1);
                    if (nextCycleCnt_s == CNT_W'(MEM_LATENCY)) begin
                        if (burstCnt_r == IDX_W'(NUM_BURSTS - 1)) begin
                            nextState_s = DONE;
                        end else begin
                            nextBurstCnt_s = burstCnt_r + IDX_W'(1);
                            nextState_s    = GAP;
                        end
                    end else begin
                        nextState_s = WRITE;
                    end
                end else begin
                    nextCycleCnt_s = cycleCnt_r;
                end
            end
            GAP: begin
                nextData_s     = dev_data;
                nextCycleCnt_s = {CNT_W{1'b0}};
                nextState_s    = WRITE;
            end
            DONE: begin
                nextState_s = RELEASE;
            end
            RELEASE: begin
                if (!BG) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = RELEASE;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State, counters, burst data and registered status outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= IDLE;
            burstCnt_r <= {IDX_W{1'b0}};
            cycleCnt_r <= {CNT_W{1'b0}};
            dataReg_r  <= 64'h0;
            busReq_r   <= 1'b0;
            dmaEnd_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= nextState_s;
            burstCnt_r <= nextBurstCnt_s;
            cycleCnt_r <= nextCycleCnt_s;
            dataReg_r  <= nextData_s;
            busReq_r   <= (nextState_s == REQ) || (nextState_s == WRITE) || (nextState_s == GAP);
            dmaEnd_r   <= (nextState_s == DONE);
            busy_r     <= (nextState_s != IDLE);
        end
    end

    assign writeStrobe_s = (state_r == WRITE) && BG;
    assign burstAddr_s   = BASE_ADDR + (16'(burstCnt_r) * 16'(WORDS_PER_BURST));

    assign BR        = busReq_r;
    assign dma_end   = dmaEnd_r;
    assign busy      = busy_r;
    assign dev_index = burstCnt_r;

    // The shared bus is driven only while the bus request is held
    assign d_readM   = busReq_r ? 1'b0          : 1'bz;
    assign d_writeM  = busReq_r ? writeStrobe_s : 1'bz;
    assign d_address = busReq_r ? burstAddr_s   : {16{1'bz}};
    assign d_data    = busReq_r ? dataReg_r     : {64{1'bz}};

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: a scoreboard of expected bus writes,
// a small memory model and a CPU-side driver that owns the data bus when BR is low.
module tb_dma_controller;

    localparam logic [63:0] CPU_PATTERN = 64'hcafe_0000_beef_0000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        cmd = 1'b0;
    logic        bgEnable = 1'b1;
    logic        monOn = 1'b0;
    wire         BG;
    wire         BR;
    wire         dma_end;
    wire         busy;
    wire  [1:0]  dev_index;
    wire  [63:0] dev_data;
    wire         d_readM;
    wire         d_writeM;
    wire  [15:0] d_address;
    wire  [63:0] d_data;

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         expQ[$];
    wr_t         e;
    int          checkCnt = 0;
    int          errCnt = 0;
    int          writeCnt = 0;
    int          endCnt = 0;
    int          cyc = 0;
    int          brCyc = 0;
    int          endCyc = 0;
    logic        prevBR = 1'b0;
    logic [15:0] mem [0:65535];

    function automatic logic [63:0] burstWord(input int b);
        return 64'h0004_0003_0002_0001 + 64'(b) * 64'h0004_0004_0004_0004;
    endfunction

    assign BG       = BR & bgEnable;
    assign dev_data = burstWord(int'(dev_index));
    assign d_data   = BR ? {64{1'bz}} : CPU_PATTERN;

    dma_controller dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .cmd       (cmd),
        .BG        (BG),
        .BR        (BR),
        .dma_end   (dma_end),
        .busy      (busy),
        .dev_index (dev_index),
        .dev_data  (dev_data),
        .d_readM   (d_readM),
        .d_writeM  (d_writeM),
        .d_address (d_address),
        .d_data    (d_data)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCnt++;
        if (actual !== expected) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Bus monitor: scoreboard compare, memory model, timing capture
    always @(negedge Clk) begin
        if (monOn) begin
            if (BR === 1'b1) begin
                checkVal("readM_low", 64'(d_readM), 64'd0);
                if (d_writeM === 1'b1) begin
                    writeCnt <= writeCnt + 1;
                    for (int i = 0; i < 4; i++) begin
                        mem[16'(d_address + 16'(i))] <= d_data[16*i +: 16];
                    end
                    if (expQ.size() == 0) begin
                        checkVal("wr_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkVal("wr_addr", 64'(d_address), 64'(e.addr));
                        checkVal("wr_data", d_data, e.data);
                    end
                end
            end else begin
                checkVal("bus_released", d_data, CPU_PATTERN);
            end
            if (BR === 1'b1 && prevBR == 1'b0) brCyc <= cyc;
            if (dma_end === 1'b1) begin
                endCnt <= endCnt + 1;
                endCyc <= cyc;
            end
        end
        prevBR <= BR;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pushTransfer();
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++) begin
                expQ.push_back('{addr: 16'h01f4 + 16'(4 * b), data: burstWord(b)});
            end
        end
    endtask

    task automatic startCmd();
        pushTransfer();
        cmd = 1'b1;
        tick();
        cmd = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) checkVal({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic waitWrites(input int target, input string tag);
        int n = 0;
        while (writeCnt < target && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) checkVal({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int e0;

        // Reset values
        repeat (2) tick();
        Reset = 1'b0;
        monOn = 1'b1;
        checkVal("rst_BR", 64'(BR), 64'd0);
        checkVal("rst_dma_end", 64'(dma_end), 64'd0);
        checkVal("rst_busy", 64'(busy), 64'd0);
        checkVal("rst_dev_index", 64'(dev_index), 64'd0);
        checkVal("rst_d_data", d_data, CPU_PATTERN);

        // Nominal transfer
        for (int i = 0; i < 16; i++) mem[16'h01f4 + 16'(i)] = 16'h0;
        w0 = writeCnt;
        e0 = endCnt;
        startCmd();
        checkVal("nom_busy", 64'(busy), 64'd1);
        waitIdle("nom");
        checkVal("nom_len", 64'(endCyc - brCyc + 1), 64'd16);
        checkVal("nom_ends", 64'(endCnt - e0), 64'd1);
        checkVal("nom_writes", 64'(writeCnt - w0), 64'd12);
        checkVal("nom_queue", 64'(expQ.size()), 64'd0);
        for (int i = 0; i < 12; i++) begin
            checkVal("nom_mem", 64'(mem[16'h01f4 + 16'(i)]), 64'(i + 1));
        end

        // Delayed grant
        bgEnable = 1'b0;
        w0 = writeCnt;
        startCmd();
        for (int i = 0; i < 5; i++) begin
            checkVal("dg_no_write", 64'(d_writeM), 64'd0);
            tick();
        end
        bgEnable = 1'b1;
        waitIdle("dg");
        checkVal("dg_len", 64'(endCyc - brCyc + 1), 64'd21);
        checkVal("dg_writes", 64'(writeCnt - w0), 64'd12);

        // Grant dropped for two cycles mid burst 1
        w0 = writeCnt;
        startCmd();
        waitWrites(w0 + 6, "gd");
        bgEnable = 1'b0;
        repeat (2) begin
            #1;
            checkVal("gd_write_low", 64'(d_writeM), 64'd0);
            checkVal("gd_BR_held", 64'(BR), 64'd1);
            tick();
        end
        bgEnable = 1'b1;
        waitIdle("gd");
        checkVal("gd_len", 64'(endCyc - brCyc + 1), 64'd18);
        checkVal("gd_writes", 64'(writeCnt - w0), 64'd12);

        // Command during WRITE is ignored
        w0 = writeCnt;
        e0 = endCnt;
        startCmd();
        waitWrites(w0 + 2, "ic");
        cmd = 1'b1;
        tick();
        cmd = 1'b0;
        waitIdle("ic");
        repeat (6) tick();
        checkVal("ic_ends", 64'(endCnt - e0), 64'd1);
        checkVal("ic_writes", 64'(writeCnt - w0), 64'd12);
        checkVal("ic_busy", 64'(busy), 64'd0);
        checkVal("ic_BR", 64'(BR), 64'd0);

        // Reset mid-transfer
        e0 = endCnt;
        w0 = writeCnt;
        startCmd();
        waitWrites(w0 + 5, "rm");
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkVal("rm_BR", 64'(BR), 64'd0);
        checkVal("rm_busy", 64'(busy), 64'd0);
        checkVal("rm_dev_index", 64'(dev_index), 64'd0);
        expQ.delete();
        repeat (4) tick();
        checkVal("rm_no_end", 64'(endCnt - e0), 64'd0);

        // Reset wins over cmd in the same cycle
        Reset = 1'b1;
        cmd = 1'b1;
        tick();
        Reset = 1'b0;
        cmd = 1'b0;
        checkVal("rc_BR", 64'(BR), 64'd0);
        checkVal("rc_busy", 64'(busy), 64'd0);

        // Restart after reset begins again at the base address
        w0 = writeCnt;
        e0 = endCnt;
        startCmd();
        waitIdle("rs");
        checkVal("rs_len", 64'(endCyc - brCyc + 1), 64'd16);
        checkVal("rs_writes", 64'(writeCnt - w0), 64'd12);
        checkVal("rs_ends", 64'(endCnt - e0), 64'd1);
        checkVal("final_queue", 64'(expQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
        $finish;
    end

endmodule
